// File: rtl/soc_system_pio_status_in.sv
// Avalon-MM input PIO: synchronized status bits, edge capture, level irq.
// Ports: clk/reset, address/chipselect/write_n/writedata/readdata, in_port, irq.
module soc_system_pio_status_in #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] s3_q, s3_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rd_q, rd_d;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wd;
  logic             we;
  logic             unused_wd;

  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign we        = chipselect && !write_n;

  always_comb begin
    hit = s2_q & ~s3_q;
    if (EDGE_TYPE == 1) begin
      hit = ~s2_q & s3_q;
    end else if (EDGE_TYPE == 2) begin
      hit = s2_q ^ s3_q;
    end
  end

  always_comb begin
    s1_d   = in_port;
    s2_d   = s1_q;
    s3_d   = s2_q;
    mask_d = mask_q;
    clr    = '0;
    if (we && address == 2'd2) begin
      mask_d = wd;
    end
    if (we && address == 2'd3) begin
      clr = wd;
    end
    // a fresh edge beats a same-cycle clear
    cap_d = (cap_q & ~clr) | hit;
    // read mux samples pre-write state
    unique case (address)
      2'd0:    rd_d = 32'(s2_q);
      2'd2:    rd_d = 32'(mask_q);
      2'd3:    rd_d = 32'(cap_q);
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      rd_q   <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_soc_system_pio_status_in.sv
// Bench for soc_system_pio_status_in: rising and any-edge instances,
// vector table, any-edge pulse sequence, random run vs sample-history model.
module tb_soc_system_pio_status_in;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  soc_system_pio_status_in #(.WIDTH(8), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd0),
    .in_port(in_port), .irq(irq0)
  );

  soc_system_pio_status_in #(.WIDTH(8), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd2),
    .in_port(in_port), .irq(irq2)
  );

  // model: smp[k] = in_port value synchronized k+1 edges ago
  logic [7:0]  smp [3];
  logic [7:0]  m_mask, m_cap0, m_cap2;
  logic [31:0] m_rd0, m_rd2;

  function automatic logic [31:0] sel(input logic [1:0] a,
                                      input logic [7:0] d,
                                      input logic [7:0] m,
                                      input logic [7:0] c);
    case (a)
      2'd0: return {24'd0, d};
      2'd2: return {24'd0, m};
      2'd3: return {24'd0, c};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] cur, prev, clr;
    if (reset) begin
      for (int k = 0; k < 3; k++) smp[k] = '0;
      m_mask = '0; m_cap0 = '0; m_cap2 = '0;
      m_rd0 = '0; m_rd2 = '0;
    end else begin
      cur  = smp[1];
      prev = smp[2];
      m_rd0 = sel(address, cur, m_mask, m_cap0);
      m_rd2 = sel(address, cur, m_mask, m_cap2);
      clr = '0;
      if (chipselect && !write_n) begin
        if (address == 2'd2) m_mask = writedata[7:0];
        if (address == 2'd3) clr = writedata[7:0];
      end
      m_cap0 = (m_cap0 & ~clr) | (cur & ~prev);
      m_cap2 = (m_cap2 & ~clr) | (cur ^ prev);
      smp[2] = smp[1];
      smp[1] = smp[0];
      smp[0] = in_port;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cycle(input logic r, input logic c, input logic wn,
                       input logic [1:0] a, input logic [31:0] w,
                       input logic [7:0] i);
    reset = r; chipselect = c; write_n = wn;
    address = a; writedata = w; in_port = i;
    @(posedge clk);
    model_step();
    #1;
    chk("model_rd0", rd0, m_rd0);
    chk("model_irq0", {31'd0, irq0}, {31'd0, |(m_cap0 & m_mask)});
    chk("model_rd2", rd2, m_rd2);
    chk("model_irq2", {31'd0, irq2}, {31'd0, |(m_cap2 & m_mask)});
  endtask

  typedef struct {
    logic        rst;
    logic        cs;
    logic        wn;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [7:0]  in;
    logic        chk;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic wn,
                     input logic [1:0] a, input logic [31:0] w,
                     input logic [7:0] i, input logic ck,
                     input logic [31:0] rd, input logic q);
    vec_t v;
    v.rst = r; v.cs = c; v.wn = wn; v.a = a; v.wd = w;
    v.in = i; v.chk = ck; v.rd = rd; v.irq = q;
    tbl.push_back(v);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) smp[k] = '0;
    m_mask = '0; m_cap0 = '0; m_cap2 = '0;
    m_rd0 = '0; m_rd2 = '0;

    add(1, 1, 0, 2, 32'hFF, 8'h00, 0, 0, 0);
    add(1, 1, 0, 3, 32'hFF, 8'h00, 0, 0, 0);
    for (int k = 0; k < 10; k++)
      add(0, 1, 1, 2'(k), 0, 8'h00, 1, 0, 0);
    add(0, 1, 0, 2, 32'hFFFF_FFFF, 8'h00, 1, 32'h00, 0);
    add(0, 0, 0, 2, 32'h00, 8'h00, 1, 32'hFF, 0);
    add(0, 1, 1, 2, 0, 8'h05, 1, 32'hFF, 0);
    add(0, 1, 1, 0, 0, 8'h05, 1, 32'h00, 0);
    add(0, 1, 1, 3, 0, 8'h05, 1, 32'h00, 1);
    add(0, 1, 1, 0, 0, 8'h05, 1, 32'h05, 1);
    add(0, 1, 1, 3, 0, 8'h05, 1, 32'h05, 1);
    add(0, 1, 0, 3, 32'h01, 8'h05, 1, 32'h05, 1);
    add(0, 1, 1, 3, 0, 8'h05, 1, 32'h04, 1);
    add(0, 1, 0, 3, 32'h04, 8'h05, 1, 32'h04, 0);
    add(0, 1, 1, 3, 0, 8'h05, 1, 32'h00, 0);
    add(0, 1, 0, 2, 32'h02, 8'h05, 1, 32'hFF, 0);
    add(0, 1, 1, 2, 0, 8'h04, 1, 32'h02, 0);
    add(0, 1, 1, 2, 0, 8'h04, 1, 32'h02, 0);
    add(0, 1, 1, 2, 0, 8'h04, 1, 32'h02, 0);
    add(0, 1, 1, 3, 0, 8'h05, 1, 32'h00, 0);
    add(0, 1, 1, 3, 0, 8'h05, 1, 32'h00, 0);
    add(0, 1, 1, 3, 0, 8'h05, 1, 32'h00, 0);
    add(0, 1, 1, 3, 0, 8'h05, 1, 32'h01, 0);
    add(0, 1, 0, 2, 32'h03, 8'h05, 1, 32'h02, 1);
    add(0, 1, 0, 3, 32'h01, 8'h05, 1, 32'h01, 0);
    add(0, 1, 0, 2, 32'hFF, 8'h05, 1, 32'h03, 0);
    add(0, 1, 1, 0, 0, 8'h0D, 1, 32'h05, 0);
    add(0, 1, 1, 0, 0, 8'h0D, 1, 32'h05, 0);
    add(0, 1, 0, 3, 32'h08, 8'h0D, 1, 32'h00, 1);
    add(0, 1, 1, 3, 0, 8'h0D, 1, 32'h08, 1);
    add(0, 1, 0, 3, 32'h08, 8'h0D, 1, 32'h08, 0);
    add(0, 1, 1, 0, 0, 8'h0D, 1, 32'h0D, 0);

    foreach (tbl[n]) begin
      cycle(tbl[n].rst, tbl[n].cs, tbl[n].wn, tbl[n].a,
            tbl[n].wd, tbl[n].in);
      if (tbl[n].chk) begin
        chk($sformatf("vec%0d_rd", n), rd0, tbl[n].rd);
        chk($sformatf("vec%0d_irq", n), {31'd0, irq0},
            {31'd0, tbl[n].irq});
      end
    end

    // any-edge pulse on bit 7: both edges captured
    cycle(0, 1, 0, 3, 32'hFF, 8'h0D);
    cycle(0, 1, 1, 3, 0, 8'h8D);
    cycle(0, 1, 1, 3, 0, 8'h8D);
    cycle(0, 1, 1, 3, 0, 8'h8D);
    cycle(0, 1, 1, 3, 0, 8'h8D);
    chk("any_rise_cap", rd2, 32'h80);
    chk("any_rise_irq", {31'd0, irq2}, 32'd1);
    chk("rise_rise_cap", rd0, 32'h80);
    cycle(0, 1, 0, 3, 32'h80, 8'h8D);
    chk("any_clr_irq", {31'd0, irq2}, 32'd0);
    cycle(0, 1, 1, 3, 0, 8'h0D);
    chk("any_cleared", rd2, 32'h00);
    cycle(0, 1, 1, 3, 0, 8'h0D);
    cycle(0, 1, 1, 3, 0, 8'h0D);
    cycle(0, 1, 1, 3, 0, 8'h0D);
    chk("any_fall_cap", rd2, 32'h80);
    chk("any_fall_irq", {31'd0, irq2}, 32'd1);
    chk("rise_fall_cap", rd0, 32'h00);
    chk("rise_fall_irq", {31'd0, irq0}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 63) == 0),
            1'($urandom), 1'($urandom), 2'($urandom),
            $urandom,
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : in_port);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
